// File: rtl/scsi_xfer_seq.sv
// Sequencer for CPU register accesses and byte-wide DMA between the SCSI IC and the longword FIFO.
// Outputs are registered from the next-state decode so they are valid in the cycle a state is entered.
module scsi_xfer_seq #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic                       nCLK,
  input  logic                       CRESET_,
  input  logic                       CPUREQ,
  input  logic                       RW,
  input  logic                       AS_,
  input  logic                       DMAEN,
  input  logic                       DMADIR,
  input  logic                       DREQ_,
  input  logic                       FIFOFULL,
  input  logic                       FIFOEMPTY,
  output logic                       SCSI_CS_,
  output logic                       RE,
  output logic                       WE,
  output logic                       DACK,
  output logic                       CPU2S,
  output logic                       S2CPU,
  output logic                       S2F,
  output logic                       F2S,
  output logic                       LBYTE_,
  output logic [$clog2(LANES)-1:0]   BO,
  output logic                       INCNI,
  output logic                       INCNO,
  output logic                       PARTIAL,
  output logic                       LS2CPU,
  output logic                       BUSY
);

  localparam int unsigned BW = $clog2(LANES);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYC - 1);
  localparam logic [BW-1:0] BO_LAST  = BW'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE, CPU_STB, CPU_TERM, DMA_STB, DMA_END, DMA_REC, FLUSH
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          CCPUREQ, CDREQ_, CDMAEN, CAS_;
  logic          rw_q, dir_q, en_q;
  logic          in_idle, bo_nz, bo_clr, dma_go, flush_go, rw_eff;

  logic          cs_n_d, re_d, we_d, dack_d, cpu2s_d, s2cpu_d, s2f_d, f2s_d;
  logic          lbyte_n_d, incni_d, incno_d, partial_d, ls2cpu_d, busy_d;
  logic [BW-1:0] bo_d;

  // Input synchronisers plus direction/enable snapshots that only move while idle
  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) begin
      CCPUREQ <= 1'b0;
      CDREQ_  <= 1'b1;
      CDMAEN  <= 1'b0;
      CAS_    <= 1'b1;
      rw_q    <= 1'b0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      CCPUREQ <= CPUREQ;
      CDREQ_  <= DREQ_;
      CDMAEN  <= DMAEN;
      CAS_    <= AS_;
      if (in_idle) begin
        rw_q  <= RW;
        dir_q <= DMADIR;
        en_q  <= CDMAEN;
      end
    end
  end

  assign in_idle  = (state == IDLE);
  assign bo_nz    = (BO != '0);
  assign rw_eff   = in_idle ? RW : rw_q;
  // A new enable or a direction flip restarts the word; no byte starts on that cycle
  assign bo_clr   = in_idle & ((CDMAEN & ~en_q) | (DMADIR != dir_q));
  assign dma_go   = CDMAEN & ~CDREQ_ & ~bo_clr &
                    (bo_nz | (dir_q ? ~FIFOEMPTY : ~FIFOFULL));
  assign flush_go = ~CDMAEN & ~dir_q & bo_nz & ~bo_clr;

  // State register
  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and strobe-counter logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (CCPUREQ)       state_d = CPU_STB;
        else if (dma_go)   state_d = DMA_STB;
        else if (flush_go) state_d = FLUSH;
      end
      CPU_STB:  if (cnt == STB_LAST) state_d = CPU_TERM;
      CPU_TERM: if (CAS_) state_d = IDLE;
      DMA_STB:  if (cnt == STB_LAST) state_d = DMA_END;
      DMA_END:  state_d = DMA_REC;
      DMA_REC:  state_d = IDLE;
      FLUSH:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    cnt_d = '0;
    if ((state_d == state) && ((state == CPU_STB) || (state == DMA_STB)))
      cnt_d = cnt + CW'(1);
  end

  // Output decode from the next state
  always_comb begin
    cs_n_d    = 1'b1;
    re_d      = 1'b0;
    we_d      = 1'b0;
    dack_d    = 1'b0;
    cpu2s_d   = 1'b0;
    s2cpu_d   = 1'b0;
    s2f_d     = 1'b0;
    f2s_d     = 1'b0;
    lbyte_n_d = 1'b1;
    incni_d   = 1'b0;
    incno_d   = 1'b0;
    partial_d = 1'b0;
    ls2cpu_d  = 1'b0;
    busy_d    = (state_d != IDLE);
    bo_d      = bo_clr ? '0 : BO;
    case (state_d)
      CPU_STB: begin
        cs_n_d  = 1'b0;
        re_d    = rw_eff;
        we_d    = ~rw_eff;
        s2cpu_d = rw_eff;
        cpu2s_d = ~rw_eff;
      end
      CPU_TERM: ls2cpu_d = 1'b1;
      DMA_STB: begin
        dack_d = 1'b1;
        if (!dir_q) begin
          re_d      = 1'b1;
          s2f_d     = 1'b1;
          lbyte_n_d = (cnt_d != STB_LAST);
        end else begin
          we_d  = 1'b1;
          f2s_d = 1'b1;
        end
      end
      DMA_END: begin
        bo_d    = BO + BW'(1);
        incni_d = ~dir_q & (BO == BO_LAST);
        incno_d = dir_q & (BO == BO_LAST);
      end
      FLUSH: begin
        incni_d   = 1'b1;
        partial_d = 1'b1;
        bo_d      = '0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) begin
      SCSI_CS_ <= 1'b1;
      RE       <= 1'b0;
      WE       <= 1'b0;
      DACK     <= 1'b0;
      CPU2S    <= 1'b0;
      S2CPU    <= 1'b0;
      S2F      <= 1'b0;
      F2S      <= 1'b0;
      LBYTE_   <= 1'b1;
      BO       <= '0;
      INCNI    <= 1'b0;
      INCNO    <= 1'b0;
      PARTIAL  <= 1'b0;
      LS2CPU   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      SCSI_CS_ <= cs_n_d;
      RE       <= re_d;
      WE       <= we_d;
      DACK     <= dack_d;
      CPU2S    <= cpu2s_d;
      S2CPU    <= s2cpu_d;
      S2F      <= s2f_d;
      F2S      <= f2s_d;
      LBYTE_   <= lbyte_n_d;
      BO       <= bo_d;
      INCNI    <= incni_d;
      INCNO    <= incno_d;
      PARTIAL  <= partial_d;
      LS2CPU   <= ls2cpu_d;
      BUSY     <= busy_d;
    end
  end

endmodule

// File: doc/scsi_xfer_seq.md
# scsi_xfer_seq

Parametrised successor to the SCSI transfer state machine. It sequences CPU register accesses and byte-wide DMA transfers between the SCSI controller IC and the longword FIFO. Lane count, strobe width and FIFO-full/empty gating are configurable, and it adds a partial-word flush on DMA termination. It sits between the CPU bus interface, the FIFO pointer logic and the SCSI IC pins.

## Interface
Parameters:
- LANES, 4: bytes per FIFO word; power of two, 2..8.
- STROBE_CYC, 2: cycles RE/WE stay asserted per access; range 1..15.

Ports:
- nCLK  in  1  state-machine clock; all flops use its rising edge.
- CRESET_  in  1  reset, asynchronous, active-low.
- CPUREQ  in  1  CPU requests a SCSI register access.
- RW  in  1  CPU direction; 1 = read from SCSI IC.
- AS_  in  1  CPU address strobe, active-low.
- DMAEN  in  1  DMA enabled.
- DMADIR  in  1  0 = SCSI→FIFO (S2F); 1 = FIFO→SCSI (F2S).
- DREQ_  in  1  SCSI IC data request, active-low.
- FIFOFULL  in  1  FIFO has no free word.
- FIFOEMPTY  in  1  FIFO holds no word.
- SCSI_CS_  out  1  SCSI IC chip select, active-low.
- RE, WE  out  1 each  read and write strobes to the SCSI IC.
- DACK  out  1  DMA acknowledge to the SCSI IC.
- CPU2S, S2CPU, S2F, F2S  out  1 each  data-path steering.
- LBYTE_  out  1  load-byte strobe into the FIFO byte lane, active-low.
- BO  out  $clog2(LANES)  current byte-lane pointer.
- INCNI  out  1  one-cycle pulse; FIFO next-in pointer advances.
- INCNO  out  1  one-cycle pulse; FIFO next-out pointer advances.
- PARTIAL  out  1  qualifies INCNI as a flushed, incomplete word.
- LS2CPU  out  1  latch SCSI data and terminate the CPU cycle.
- BUSY  out  1  state is not IDLE.

## Operation
- Inputs CPUREQ, DREQ_, DMAEN and AS_ are registered once (C-prefixed copies). All decisions use the registered copies.
- All outputs are registered and decoded from the next state, so they are valid in the cycle the state is entered.
- Reset values: state IDLE, BO = 0, SCSI_CS_ = 1, LBYTE_ = 1, all other outputs 0, strobe counter 0.
- IDLE arbitration, in priority order:
  - CCPUREQ → CPU_STB.
  - CDMAEN & ~CDREQ_ & S2F & (BO≠0 | ~FIFOFULL) → DMA_STB.
  - CDMAEN & ~CDREQ_ & F2S & (BO≠0 | ~FIFOEMPTY) → DMA_STB.
  - ~CDMAEN & S2F & BO≠0 → FLUSH.
  - Otherwise stay in IDLE.
- CPU_STB: SCSI_CS_ = 0; RE = RW; WE = ~RW; S2CPU = RW; CPU2S = ~RW. Held for STROBE_CYC cycles, then → CPU_TERM.
- CPU_TERM: SCSI_CS_ = 1; LS2CPU = 1, held while CAS_ = 0. When CAS_ = 1: LS2CPU = 0 and → IDLE.
- DMA_STB: DACK = 1 for STROBE_CYC cycles.
  - S2F: RE = 1 and S2F = 1; LBYTE_ = 0 in the last strobe cycle only.
  - F2S: WE = 1 and F2S = 1.
  - Then → DMA_END.
- DMA_END: DACK, RE and WE drop; BO ← BO+1 mod LANES. If the old BO = LANES-1, pulse INCNI (S2F) or INCNO (F2S). → DMA_REC.
- DMA_REC: one idle cycle so the next DREQ_ is re-sampled. → IDLE.
- FLUSH: INCNI = 1 and PARTIAL = 1 for one cycle; BO ← 0; → IDLE.
- BO ← 0 on a rising CDMAEN and on any DMADIR change while in IDLE.
- DMADIR, RW and DMAEN changes during a transfer are ignored until IDLE.
- FIFOFULL and FIFOEMPTY are checked only when BO = 0, i.e. at the start of a word. Mid-word bytes always proceed.

## Timing
- CPU access: CPUREQ sampled at edge n, CPU_STB entered at edge n+1, SCSI_CS_ low for STROBE_CYC cycles. LS2CPU rises at edge n+1+STROBE_CYC.
- After AS_ rises, LS2CPU falls 2 edges later (1 sync + 1 state).
- DMA byte: DACK rises 2 edges after DREQ_ falls. Minimum byte period is STROBE_CYC+3 cycles (IDLE + STB + END + REC); default 5 cycles, 20 per longword.
- INCNI/INCNO pulse is exactly 1 cycle, in DMA_END of lane LANES-1.
- If CPUREQ and DREQ_ are both pending in IDLE, the CPU wins. DMA resumes after CPU_TERM; BO is preserved.
- Reset asserted mid-transfer: everything returns to reset values immediately (asynchronous); no INCNI/INCNO is issued.

## Test plan
- CPU read, STROBE_CYC = 2: CPUREQ = 1, RW = 1 → SCSI_CS_ low for 2 cycles, RE = 1, S2CPU = 1. LS2CPU holds until AS_ rises, then clears 2 cycles later.
- S2F, 4 bytes, LANES = 4, DREQ_ held low → 4 DACK pulses 5 cycles apart, BO sequence 0,1,2,3,0. Single INCNI after the 4th byte; 4 LBYTE_ pulses.
- F2S with FIFOEMPTY = 1 at BO = 0 → no DACK. Deassert FIFOEMPTY → transfer starts 2 cycles later, WE = 1, F2S = 1; INCNO after 4 bytes.
- S2F with FIFOFULL raised at BO = 2 → bytes 2 and 3 complete, INCNI issued. The next word is blocked until FIFOFULL = 0.
- S2F 3 bytes, then DMAEN = 0 → FLUSH: INCNI = 1 with PARTIAL = 1 for 1 cycle, BO returns to 0.
- CPUREQ and DREQ_ asserted in the same cycle → CPU access first, then the DMA byte with BO unchanged. CRESET_ pulsed inside DMA_STB → DACK = 0 and BO = 0 immediately, no pointer pulse.
